activation_drain: RTL and testbench

- Receive side of the activation unit: issues calc enables into `activation` and tracks in-flight beats through its fixed pipeline latency.
- Captures `data_o` vectors into a small FIFO and re-emits them on a valid/ready stream to the output stage.
- Credit-based: upstream is throttled so no activation result is ever dropped, because the activation unit itself has no backpressure.

---
 rtl/activation_drain_pkg.sv | 14 +
 rtl/activation_drain_fifo.sv | 54 +++++
 rtl/activation_drain.sv | 102 ++++++++++
 tb/tb_activation_drain.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_drain_pkg.sv
// Shared constants for the activation drain block.
package activation_drain_pkg;

   localparam int unsigned ActDrainLanes   = 16;
   localparam int unsigned ActDrainWo      = 8;
   localparam int unsigned ActDrainLatency = 2;
   localparam int unsigned ActDrainDepth   = 4;

   // Pointer width; a single-entry FIFO still needs one pointer bit.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/activation_drain_fifo.sv
// Registered DEPTH x W FIFO with synchronous clear; clear wins over push/pop.
module activation_drain_fifo
   import activation_drain_pkg::*;
#(
   parameter int unsigned DEPTH = ActDrainDepth,
   parameter int unsigned W     = ActDrainLanes * ActDrainWo
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int unsigned AW = ptr_width(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [CW-1:0] count_q;
   logic          do_pop;

   assign do_pop  = pop_i & (count_q != '0);
   assign data_o  = mem_q[rptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (do_pop) rptr_q <= rptr_q + AW'(1);
         if (push_i && !do_pop)      count_q <= count_q + CW'(1);
         else if (!push_i && do_pop) count_q <= count_q - CW'(1);
      end
   end

endmodule

// File: rtl/activation_drain.sv
// Receive side of the activation unit: credit-throttled issue, latency tracking, output FIFO.
// Optional ACTIVATION_DRAIN_STATS_EN adds saturating pop/stall counters.
module activation_drain
   import activation_drain_pkg::*;
#(
   parameter int unsigned N       = ActDrainLanes,
   parameter int unsigned WO      = ActDrainWo,
   parameter int unsigned LATENCY = ActDrainLatency,
   parameter int unsigned DEPTH   = ActDrainDepth
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         valid_i,
   output logic                         ready_o,
   output logic                         calc_en_o,
   input  logic [N*WO-1:0]              act_data_i,
   input  logic                         clear_i,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [N*WO-1:0]              data_o,
   output logic [$clog2(DEPTH+1)-1:0]   inflight_o
`ifdef ACTIVATION_DRAIN_STATS_EN
   ,
   output logic [31:0]                  beats_o,
   output logic [31:0]                  stall_o
`endif
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [CW-1:0]      cred_q;
   logic [LATENCY-1:0] vpipe_q;
   logic               pop;
   logic               push;
   logic               fifo_empty;
   logic               fifo_full;

   // Credits count only registered state, so a pop frees a slot one cycle later.
   assign ready_o    = (cred_q != '0);
   assign calc_en_o  = valid_i & ready_o & ~clear_i;
   assign pop        = valid_o & ready_i;
   assign push       = vpipe_q[LATENCY-1];
   assign valid_o    = ~fifo_empty;
   assign inflight_o = CW'(DEPTH) - cred_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cred_q <= CW'(DEPTH);
      end else if (clear_i) begin
         cred_q <= CW'(DEPTH);
      end else if (calc_en_o && !pop) begin
         cred_q <= cred_q - CW'(1);
      end else if (!calc_en_o && pop) begin
         cred_q <= cred_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vpipe_q <= '0;
      end else if (clear_i) begin
         vpipe_q <= '0;
      end else begin
         vpipe_q[0] <= calc_en_o;
         for (int k = 1; k < int'(LATENCY); k++) vpipe_q[k] <= vpipe_q[k-1];
      end
   end

   activation_drain_fifo #(
      .DEPTH (DEPTH),
      .W     (N * WO)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (push & ~clear_i),
      .data_i  (act_data_i),
      .pop_i   (pop),
      .data_o  (data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && fifo_full && !clear_i));

`ifdef ACTIVATION_DRAIN_STATS_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beats_o <= '0;
         stall_o <= '0;
      end else if (clear_i) begin
         beats_o <= '0;
         stall_o <= '0;
      end else begin
         if (pop && beats_o != '1) beats_o <= beats_o + 32'd1;
         if (valid_i && !ready_o && stall_o != '1) stall_o <= stall_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_activation_drain.sv
// Randomized bench for activation_drain against a queue-based reference model.
module tb_activation_drain;

   localparam int W = 128;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         valid_i, ready_i, clear_i;
   logic [W-1:0] act_data;
   int           sel;
   logic [2:0]   v_dut, rdy, cen, vld;
   logic [W-1:0] dat [3];
   logic [2:0]   inf0;
   logic [1:0]   inf1;
   logic [3:0]   inf2;
`ifdef ACTIVATION_DRAIN_STATS_EN
   logic [31:0]  beats0, stall0, beats1, stall1, beats2, stall2;
`endif

   assign v_dut[0] = valid_i & (sel == 0);
   assign v_dut[1] = valid_i & (sel == 1);
   assign v_dut[2] = valid_i & (sel == 2);

   activation_drain #(.N(16), .WO(8), .LATENCY(2), .DEPTH(4)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v_dut[0]), .ready_o(rdy[0]), .calc_en_o(cen[0]),
      .act_data_i(act_data), .clear_i(clear_i), .valid_o(vld[0]), .ready_i(ready_i),
      .data_o(dat[0]), .inflight_o(inf0)
`ifdef ACTIVATION_DRAIN_STATS_EN
      , .beats_o(beats0), .stall_o(stall0)
`endif
   );

   activation_drain #(.N(16), .WO(8), .LATENCY(1), .DEPTH(2)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v_dut[1]), .ready_o(rdy[1]), .calc_en_o(cen[1]),
      .act_data_i(act_data), .clear_i(clear_i), .valid_o(vld[1]), .ready_i(ready_i),
      .data_o(dat[1]), .inflight_o(inf1)
`ifdef ACTIVATION_DRAIN_STATS_EN
      , .beats_o(beats1), .stall_o(stall1)
`endif
   );

   activation_drain #(.N(16), .WO(8), .LATENCY(3), .DEPTH(8)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v_dut[2]), .ready_o(rdy[2]), .calc_en_o(cen[2]),
      .act_data_i(act_data), .clear_i(clear_i), .valid_o(vld[2]), .ready_i(ready_i),
      .data_o(dat[2]), .inflight_o(inf2)
`ifdef ACTIVATION_DRAIN_STATS_EN
      , .beats_o(beats2), .stall_o(stall2)
`endif
   );

   // Reference model: every accepted beat waits in order until issue + LATENCY + 1.
   typedef struct {
      logic [W-1:0] d;
      int           vis;
   } beat_t;

   beat_t        oq[$];
   logic [W-1:0] sched_d [64];
   bit           sched_v [64];
   int           lat, dep, cyc;
   int           n_tests, n_fail;
   int           n_stall, n_pops, n_cen_obs;
   logic [W-1:0] payload;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d, dut %0d)", tag, got, exp, cyc, sel);
      end
   endtask

   task automatic model_flush();
      oq.delete();
      for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;
      n_stall = 0;
      n_pops  = 0;
   endtask

   task automatic step();
      int    slot;
      bit    e_rdy, e_vld, e_cen;
      int    got_inf;
      beat_t b;
      slot = cyc % 64;
      if (sched_v[slot]) begin
         act_data      = sched_d[slot];
         sched_v[slot] = 1'b0;
      end else begin
         act_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(negedge clk);
      e_rdy = oq.size() < dep;
      e_vld = (oq.size() > 0) && (oq[0].vis <= cyc);
      e_cen = valid_i && e_rdy && !clear_i;
      case (sel)
         0:       got_inf = int'(inf0);
         1:       got_inf = int'(inf1);
         default: got_inf = int'(inf2);
      endcase
      chk("ready_o", W'(rdy[sel]), W'(e_rdy));
      chk("calc_en_o", W'(cen[sel]), W'(e_cen));
      chk("valid_o", W'(vld[sel]), W'(e_vld));
      chk("inflight_o", W'(got_inf), W'(oq.size()));
      if (e_vld) chk("data_o", dat[sel], oq[0].d);
      n_cen_obs += int'(cen[sel]);
      if (clear_i) begin
         model_flush();
      end else begin
         if (sel == 0 && valid_i && !e_rdy) n_stall++;
         if (e_vld && ready_i) begin
            void'(oq.pop_front());
            if (sel == 0) n_pops++;
         end
         if (e_cen) begin
            b.d   = payload;
            b.vis = cyc + lat + 1;
            oq.push_back(b);
            sched_d[(cyc + lat) % 64] = payload;
            sched_v[(cyc + lat) % 64] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(input int n);
      valid_i = 1'b0;
      ready_i = 1'b1;
      repeat (n) step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end (cycle %0d)", cyc);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, k;
      valid_i = 1'b0; ready_i = 1'b0; clear_i = 1'b0;
      sel = 0; lat = 2; dep = 4; cyc = 0; payload = '0;
      n_tests = 0; n_fail = 0; n_cen_obs = 0;
      act_data = '0;
      model_flush();

      repeat (2) @(posedge clk);
      #1;
      chk("rst_data_o", dat[0], '0);
      chk("rst_valid_o", W'(vld), '0);
      chk("rst_ready_o", W'(rdy), W'(3'b111));
      chk("rst_inflight_o", W'(inf0), '0);
      rst_n = 1'b1;
      step();

      // Streaming: one beat per cycle, payload = beat index.
      ready_i = 1'b1;
      valid_i = 1'b1;
      for (int i = 0; i < 64; i++) begin
         payload = W'(i);
         step();
      end
      drain(8);

      // Backpressure: only DEPTH beats may be accepted.
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      ready_i = 1'b0;
      valid_i = 1'b1;
      base = n_cen_obs;
      for (int i = 0; i < 10; i++) begin
         payload = W'(i);
         step();
      end
      chk("bp_accepted", W'(n_cen_obs - base), W'(4));
`ifdef ACTIVATION_DRAIN_STATS_EN
      chk("stall_o", W'(stall0), W'(6));
      chk("stall_o_model", W'(stall0), W'(n_stall));
`endif
      drain(8);

      // Random valid/ready over 200 accepted beats.
      base = n_cen_obs;
      k = 0;
      while (k < 3000 && (n_cen_obs - base) < 200) begin
         valid_i = ($urandom_range(0, 3) != 0);
         ready_i = $urandom_range(0, 1) != 0;
         payload = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
         k++;
      end
      chk("rand_accepted", W'(n_cen_obs - base), W'(200));
      drain(10);
`ifdef ACTIVATION_DRAIN_STATS_EN
      chk("beats_o", W'(beats0), W'(n_pops));
`endif

      // Clear with beats both in the pipeline and in the FIFO.
      ready_i = 1'b0;
      valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         payload = W'(32'hC000 + i);
         step();
      end
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      valid_i = 1'b0;
      step();
      chk("clr_valid_o", W'(vld[0]), '0);
      chk("clr_inflight_o", W'(inf0), '0);
      drain(10);
      valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         payload = W'(32'hD000 + i);
         step();
      end
      drain(8);

      // Asynchronous reset in the middle of a stream.
      valid_i = 1'b1;
      for (int i = 0; i < 37; i++) begin
         ready_i = ($urandom_range(0, 3) != 0);
         payload = W'(1000 + i);
         step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid_o", W'(vld[0]), '0);
      chk("arst_ready_o", W'(rdy[0]), W'(1));
      chk("arst_inflight_o", W'(inf0), '0);
      model_flush();
      valid_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc += 2;
      ready_i = 1'b1;
      valid_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         payload = W'(2000 + i);
         step();
      end
      drain(8);

      // Other latency/depth configurations.
      for (int s = 1; s <= 2; s++) begin
         sel = s;
         lat = (s == 1) ? 1 : 3;
         dep = (s == 1) ? 2 : 8;
         model_flush();
         for (int i = 0; i < 60; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            payload = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
         end
         ready_i = 1'b1;
         valid_i = 1'b1;
         for (int i = 0; i < 30; i++) begin
            payload = W'(s * 256 + i);
            step();
         end
         drain(12);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
